// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - bimodal/gshare branch predictor with PHT, GHR, BTB and statistics
module branch_predictor_gshare #(
    parameter int PHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 6,
    parameter int BTB_ENTRIES = 16,
    parameter int MODE        = 0,
    localparam int IDXW       = $clog2(PHT_ENTRIES),
    localparam int BW         = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            proc_reset,
    input  logic            stall,
    input  logic [31:0]     if_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    output logic            btb_hit,
    output logic [IDXW-1:0] pred_idx,
    input  logic            upd_valid,
    input  logic [31:0]     upd_pc,
    input  logic [IDXW-1:0] upd_idx,
    input  logic            upd_taken,
    input  logic [31:0]     upd_target,
    input  logic            upd_mispredict,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispredict_cnt
);

    localparam int TAGW = 30 - BW;
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0]    pht [PHT_ENTRIES];
    logic [GHR_BITS-1:0]    ghr;
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag [BTB_ENTRIES];
    logic [29:0]            btb_target [BTB_ENTRIES];

    logic [IDXW-1:0]        base_idx;
    logic [IDXW-1:0]        ghr_ext;
    logic [IDXW-1:0]        look_idx;
    logic [BW-1:0]          look_entry;
    logic [TAGW-1:0]        look_tag;
    logic [BW-1:0]          upd_entry;
    logic                   do_upd;
    logic [GHR_BITS:0]      ghr_shift;

    // Word-offset bits of the PCs never take part in indexing.
    wire unused_low_bits = ^{if_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign do_upd     = upd_valid && !stall;
    assign base_idx   = if_pc[IDXW+1:2];
    assign look_entry = if_pc[BW+1:2];
    assign look_tag   = if_pc[31:BW+2];
    assign upd_entry  = upd_pc[BW+1:2];
    // One extra bit on the left lets the shift work even for a 1-bit history.
    assign ghr_shift  = {ghr, upd_taken};

    // History is zero-extended on the left before the XOR with the PC index.
    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_BITS-1:0] = ghr;
    end

    // Combinational lookup: index, BTB match and next-PC selection.
    always_comb begin
        look_idx    = (MODE == 1) ? (base_idx ^ ghr_ext) : base_idx;
        pred_idx    = look_idx;
        btb_hit     = btb_valid[look_entry] && (btb_tag[look_entry] == look_tag);
        pred_taken  = btb_hit && pht[look_idx][CTR_BITS-1];
        pred_target = pred_taken ? {btb_target[look_entry], 2'b00} : (if_pc + 32'd4);
    end

    // PHT training uses the index captured at fetch, never one recomputed now.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CTR_WEAK_NT;
            end
        end else if (do_upd) begin
            if (upd_taken && pht[upd_idx] != CTR_MAX) begin
                pht[upd_idx] <= pht[upd_idx] + 1'b1;
            end else if (!upd_taken && pht[upd_idx] != '0) begin
                pht[upd_idx] <= pht[upd_idx] - 1'b1;
            end
        end
    end

    // Global history: newest outcome shifts in at the LSB.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            ghr <= '0;
        end else if (do_upd) begin
            ghr <= ghr_shift[GHR_BITS-1:0];
        end
    end

    // BTB valid bits; only taken branches allocate, overwriting any alias.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            btb_valid <= '0;
        end else if (do_upd && upd_taken) begin
            btb_valid[upd_entry] <= 1'b1;
        end
    end

    // BTB tag/target payload; meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (do_upd && upd_taken) begin
            btb_tag[upd_entry]    <= upd_pc[31:BW+2];
            btb_target[upd_entry] <= upd_target[31:2];
        end
    end

    // Saturating resolved-branch and mispredict statistics.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (do_upd) begin
            if (branch_cnt != 16'hFFFF) begin
                branch_cnt <= branch_cnt + 16'd1;
            end
            if (upd_mispredict && mispredict_cnt != 16'hFFFF) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - randomized model-based bench for bimodal and gshare predictors
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        proc_reset;
    logic        stall;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic        b_taken, g_taken, b_hit, g_hit;
    logic [31:0] b_target, g_target;
    logic [5:0]  b_idx, g_idx;
    logic [15:0] b_bcnt, g_bcnt, b_mcnt, g_mcnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state: [0] bimodal instance, [1] gshare instance
    int          pht_m [2][64];
    int          ghr_m [2];
    int          ghr_len [2] = '{6, 4};
    bit          btb_v [16];
    int unsigned btb_tag_m [16];
    int unsigned btb_tgt_m [16];
    int unsigned bcnt_m, mcnt_m;

    always #5 clk = ~clk;

    branch_predictor_gshare #(.MODE(0)) u_bim (
        .clk(clk), .proc_reset(proc_reset), .stall(stall), .if_pc(if_pc),
        .pred_taken(b_taken), .pred_target(b_target), .btb_hit(b_hit), .pred_idx(b_idx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .branch_cnt(b_bcnt), .mispredict_cnt(b_mcnt)
    );

    branch_predictor_gshare #(.MODE(1), .GHR_BITS(4)) u_gsh (
        .clk(clk), .proc_reset(proc_reset), .stall(stall), .if_pc(if_pc),
        .pred_taken(g_taken), .pred_target(g_target), .btb_hit(g_hit), .pred_idx(g_idx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .branch_cnt(g_bcnt), .mispredict_cnt(g_mcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) pht_m[m][i] = 1;
            ghr_m[m] = 0;
        end
        for (int i = 0; i < 16; i++) btb_v[i] = 1'b0;
        bcnt_m = 0;
        mcnt_m = 0;
    endtask

    task automatic model_commit();
        int b;
        if (!(upd_valid && !stall)) return;
        for (int m = 0; m < 2; m++) begin
            if (upd_taken) pht_m[m][upd_idx] = (pht_m[m][upd_idx] < 3) ? pht_m[m][upd_idx] + 1 : 3;
            else           pht_m[m][upd_idx] = (pht_m[m][upd_idx] > 0) ? pht_m[m][upd_idx] - 1 : 0;
            ghr_m[m] = ((ghr_m[m] * 2) + int'(upd_taken)) % (1 << ghr_len[m]);
        end
        if (upd_taken) begin
            b = int'((upd_pc / 4) % 16);
            btb_v[b]     = 1'b1;
            btb_tag_m[b] = upd_pc / 64;
            btb_tgt_m[b] = upd_target & 32'hFFFF_FFFC;
        end
        if (bcnt_m < 65535) bcnt_m++;
        if (upd_mispredict && mcnt_m < 65535) mcnt_m++;
    endtask

    function automatic int m_idx(input int m, input logic [31:0] pc);
        return int'((pc / 4) % 64) ^ ((m == 1) ? ghr_m[1] : 0);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int b;
        b = int'((pc / 4) % 16);
        return btb_v[b] && (btb_tag_m[b] == pc / 64);
    endfunction

    function automatic bit m_taken(input int m, input logic [31:0] pc);
        return m_hit(pc) && (pht_m[m][m_idx(m, pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input int m, input logic [31:0] pc);
        logic [31:0] nxt;
        nxt = pc + 32'd4;
        return m_taken(m, pc) ? btb_tgt_m[(pc / 4) % 16] : nxt;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (!proc_reset) model_commit();
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc;
        #1;
        check("bim_taken",  {31'd0, b_taken}, {31'd0, m_taken(0, pc)});
        check("bim_hit",    {31'd0, b_hit},   {31'd0, m_hit(pc)});
        check("bim_target", b_target,         m_target(0, pc));
        check("bim_idx",    {26'd0, b_idx},   m_idx(0, pc));
        check("gsh_taken",  {31'd0, g_taken}, {31'd0, m_taken(1, pc)});
        check("gsh_hit",    {31'd0, g_hit},   {31'd0, m_hit(pc)});
        check("gsh_target", g_target,         m_target(1, pc));
        check("gsh_idx",    {26'd0, g_idx},   m_idx(1, pc));
    endtask

    task automatic check_counts();
        check("bim_branch_cnt", {16'd0, b_bcnt}, bcnt_m);
        check("bim_misp_cnt",   {16'd0, b_mcnt}, mcnt_m);
        check("gsh_branch_cnt", {16'd0, g_bcnt}, bcnt_m);
        check("gsh_misp_cnt",   {16'd0, g_mcnt}, mcnt_m);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [5:0] idx, input logic tk,
                       input logic [31:0] tgt, input logic misp);
        upd_valid = 1'b1; upd_pc = pc; upd_idx = idx; upd_taken = tk;
        upd_target = tgt; upd_mispredict = misp;
        cycle();
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        proc_reset = 1'b1;
        model_reset();
        cycle();
        proc_reset = 1'b0;
    endtask

    logic [31:0] pool [6] = '{32'h100, 32'h140, 32'h200, 32'h1000, 32'hFFFF_FFFC, 32'h3C0};

    initial begin
        stall = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_idx = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
        proc_reset = 1'b1;
        model_reset();
        cycle(); cycle();
        proc_reset = 1'b0;

        // reset state
        if_pc = 32'h40; #1;
        check("rst_taken",  {31'd0, b_taken}, 32'd0);
        check("rst_hit",    {31'd0, b_hit},   32'd0);
        check("rst_target", b_target,         32'h44);
        check("rst_idx",    {26'd0, b_idx},   32'h10);
        check("rst_bcnt",   {16'd0, b_bcnt},  32'd0);
        look(32'h40);

        // bimodal training at idx 0
        upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b1);
        if_pc = 32'h100; #1;
        check("train_hit",    {31'd0, b_hit},   32'd1);
        check("train_taken",  {31'd0, b_taken}, 32'd1);
        check("train_target", b_target,         32'h200);
        upd(32'h100, 6'd0, 1'b0, 32'h200, 1'b1);
        if_pc = 32'h100; #1;
        check("train_nt1_taken", {31'd0, b_taken}, 32'd1);
        upd(32'h100, 6'd0, 1'b0, 32'h200, 1'b0);
        if_pc = 32'h100; #1;
        check("train_nt2_taken",  {31'd0, b_taken}, 32'd0);
        check("train_nt2_target", b_target,         32'h104);
        look(32'h100);

        // stall blocks every state update
        stall = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h180; upd_idx = 6'd0; upd_taken = 1'b1;
        upd_target = 32'h400; upd_mispredict = 1'b1;
        repeat (3) cycle();
        upd_valid = 1'b0; stall = 1'b0;
        if_pc = 32'h100; #1;
        check("stall_taken", {31'd0, b_taken}, 32'd0);
        check("stall_bcnt",  {16'd0, b_bcnt},  32'd4);
        check("stall_mcnt",  {16'd0, b_mcnt},  32'd2);
        if_pc = 32'h180; #1;
        check("stall_btb",   {31'd0, b_hit},   32'd0);
        look(32'h180);
        check_counts();

        // counter saturation, then statistics saturation
        repeat (5) upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b0);
        upd(32'h100, 6'd0, 1'b0, 32'h200, 1'b0);
        if_pc = 32'h100; #1;
        check("sat_taken", {31'd0, b_taken}, 32'd1);
        upd_valid = 1'b1; upd_pc = 32'h100; upd_idx = 6'd0; upd_taken = 1'b1;
        upd_target = 32'h200; upd_mispredict = 1'b1;
        repeat (70000) cycle();
        upd_valid = 1'b0;
        check("sat_bcnt", {16'd0, b_bcnt}, 32'hFFFF);
        check("sat_mcnt", {16'd0, b_mcnt}, 32'hFFFF);
        check_counts();

        // gshare index after two taken outcomes
        do_reset();
        upd(32'h300, 6'd5, 1'b1, 32'h500, 1'b0);
        upd(32'h340, 6'd9, 1'b1, 32'h600, 1'b0);
        if_pc = 32'h100; #1;
        check("gsh_idx_0011", {26'd0, g_idx}, 32'h03);
        look(32'h100);

        // BTB alias: 0x100 and 0x140 share entry 0
        do_reset();
        upd(32'h100, 6'd0, 1'b1, 32'h200, 1'b0);
        upd(32'h140, 6'd0, 1'b1, 32'h300, 1'b0);
        if_pc = 32'h100; #1;
        check("alias_old_hit",    {31'd0, b_hit}, 32'd0);
        check("alias_old_target", b_target,       32'h104);
        if_pc = 32'h140; #1;
        check("alias_new_hit",    {31'd0, b_hit}, 32'd1);
        look(32'h140);

        // asynchronous reset mid-cycle, update committed on the releasing edge
        #2;
        proc_reset = 1'b1;
        model_reset();
        #1;
        check("async_bcnt", {16'd0, b_bcnt}, 32'd0);
        if_pc = 32'h140; #1;
        check("async_hit",  {31'd0, b_hit},  32'd0);
        upd_valid = 1'b1; upd_pc = 32'h200; upd_idx = 6'd3; upd_taken = 1'b1;
        upd_target = 32'h800; upd_mispredict = 1'b0;
        cycle();
        proc_reset = 1'b0;
        cycle();
        upd_valid = 1'b0;
        check("release_bcnt", {16'd0, b_bcnt}, 32'd1);
        look(32'h200);

        // randomized traffic against the reference model
        for (int n = 0; n < 2500; n++) begin
            logic [31:0] lpc;
            stall          = ($urandom_range(0, 7) == 0);
            upd_valid      = $urandom_range(0, 1);
            upd_pc         = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                         : pool[$urandom_range(0, 5)];
            upd_idx        = 6'($urandom_range(0, 63));
            upd_taken      = $urandom_range(0, 1);
            upd_target     = $urandom() & 32'hFFFF_FFFC;
            upd_mispredict = $urandom_range(0, 1);
            lpc = ($urandom_range(0, 4) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                              : pool[$urandom_range(0, 5)];
            look(lpc);
            check_counts();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
